// File: rtl/imm_ext_pkg.sv
// Shared mode encodings and the immediate-extension function for imm_extend_pipe.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    MODE_SIGN   = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } imm_mode_e;

  localparam int unsigned EXT_MAX_W = 64;

  // Works on a fixed 64-bit carrier; callers zero-extend the immediate in and size-cast the result.
  function automatic logic [EXT_MAX_W-1:0] imm_ext_f(
    input logic [EXT_MAX_W-1:0] imm,
    input logic [1:0]           mode,
    input int unsigned          in_w,
    input int unsigned          out_w,
    input int unsigned          br_shift
  );
    logic [EXT_MAX_W-1:0] field;
    logic [EXT_MAX_W-1:0] sext;
    logic [EXT_MAX_W-1:0] res;
    field = imm & ~({EXT_MAX_W{1'b1}} << in_w);
    sext  = field;
    if (field[in_w-1])
      sext = field | ({EXT_MAX_W{1'b1}} << in_w);
    res = sext;
    case (imm_mode_e'(mode))
      MODE_SIGN:   res = sext;
      MODE_ZERO:   res = field;
      MODE_UPPER:  res = field << (out_w - in_w);
      MODE_BRANCH: res = sext << br_shift;
      default:     res = sext;
    endcase
    return res & ~({EXT_MAX_W{1'b1}} << out_w);
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic 2-entry valid/ready register: main entry drives the outputs, skid entry
// absorbs one transfer when downstream stalls. in_ready is a registered !skid_valid.
module pipe_skid_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] skid_data;
  logic         skid_valid;
  logic         skid_valid_next;
  logic         accept;
  logic         drain;
  logic         main_free;

  always_comb begin
    accept          = in_valid & in_ready;
    drain           = out_valid & out_ready;
    main_free       = !out_valid || drain;
    skid_valid_next = skid_valid;
    if (main_free)
      skid_valid_next = 1'b0;
    else if (accept)
      skid_valid_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b0;
    end else begin
      skid_valid <= skid_valid_next;
      in_ready   <= !skid_valid_next;
      // A full skid always wins the main slot; accept is impossible then since in_ready=0.
      if (main_free) begin
        if (skid_valid) begin
          out_data  <= skid_data;
          out_valid <= 1'b1;
        end else if (accept) begin
          out_data  <= in_data;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined MIPS immediate-extension stage with a 2-entry skid register.
// Optional transfer/stall counters are enabled by defining IMM_EXT_STATS_EN.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W     = 16,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned BR_SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
`ifdef IMM_EXT_STATS_EN
  ,
  output logic [31:0]      xfer_count,
  output logic [31:0]      stall_count
`endif
);

  logic [OUT_W-1:0] ext_data;

  always_comb begin
    ext_data = OUT_W'(imm_ext_f(EXT_MAX_W'(in_imm), in_mode, IN_W, OUT_W, BR_SHIFT));
  end

  pipe_skid_reg #(
    .W (OUT_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (ext_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

`ifdef IMM_EXT_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_count  <= '0;
      stall_count <= '0;
    end else begin
      if (out_valid && out_ready)
        xfer_count <= xfer_count + 32'd1;
      if (out_valid && !out_ready && (stall_count != '1))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: queue-based reference model plus directed cases.
module tb_imm_extend_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef IMM_EXT_STATS_EN
  logic [31:0] xfer_count;
  logic [31:0] stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  imm_extend_pipe #(
    .IN_W     (16),
    .OUT_W    (32),
    .BR_SHIFT (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef IMM_EXT_STATS_EN
    ,
    .xfer_count  (xfer_count),
    .stall_count (stall_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    int s;
    s = int'($signed(imm));
    case (mode)
      2'd0:    return s;
      2'd1:    return {16'h0000, imm};
      2'd2:    return {imm, 16'h0000};
      default: return s * 4;
    endcase
  endfunction

  // Reference model: a FIFO of capacity 2 whose ready flag is "fewer than two held".
  logic [31:0] q[$];
  bit          m_ready = 1'b0;
  logic [31:0] m_xfer  = '0;
  logic [31:0] m_stall = '0;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_ready = 1'b0;
      m_xfer  = '0;
      m_stall = '0;
    end else begin
      bit pushing;
      pushing = in_valid && m_ready;
      if (q.size() != 0) begin
        if (out_ready) begin
          void'(q.pop_front());
          m_xfer = m_xfer + 1;
        end else begin
          m_stall = m_stall + 1;
        end
      end
      if (pushing)
        q.push_back(ref_ext(in_imm, in_mode));
      m_ready = (q.size() < 2);
    end
  end

  always @(negedge clk) begin
    check("in_ready", {63'b0, in_ready}, {63'b0, m_ready});
    check("out_valid", {63'b0, out_valid}, {63'b0, q.size() != 0});
    if (q.size() != 0)
      check("out_data", {32'b0, out_data}, {32'b0, q[0]});
`ifdef IMM_EXT_STATS_EN
    check("xfer_count", {32'b0, xfer_count}, {32'b0, m_xfer});
    check("stall_count", {32'b0, stall_count}, {32'b0, m_stall});
`endif
  end

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] exp1 [4];
  int          waited;

  initial begin
    exp1[0] = 32'hFFFF8001;
    exp1[1] = 32'h00008001;
    exp1[2] = 32'h80010000;
    exp1[3] = 32'hFFFE0004;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_mode   = '0;
    out_ready = 1'b0;

    // Model pins
    for (int m = 0; m < 4; m++)
      check("model_8001", {32'b0, ref_ext(16'h8001, 2'(m))}, {32'b0, exp1[m]});
    check("model_7fff_sign", {32'b0, ref_ext(16'h7FFF, 2'd0)}, 64'h0000_0000_0000_7FFF);
    check("model_7fff_branch", {32'b0, ref_ext(16'h7FFF, 2'd3)}, 64'h0000_0000_0001_FFFC);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready}, 64'd0);
    check("rst_out_data", {32'b0, out_data}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {63'b0, in_ready}, 64'd1);

    // 1: all four modes of 0x8001, one cycle latency
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      in_valid = 1'b1;
      in_imm   = 16'h8001;
      in_mode  = 2'(m);
      @(negedge clk);
      in_valid = 1'b0;
      check("t1_valid", {63'b0, out_valid}, 64'd1);
      check("t1_data", {32'b0, out_data}, {32'b0, exp1[m]});
      @(negedge clk);
    end

    // 2: 0x7FFF sign and branch
    in_valid = 1'b1; in_imm = 16'h7FFF; in_mode = 2'd0;
    @(negedge clk);
    check("t2_sign", {32'b0, out_data}, 64'h0000_7FFF);
    in_mode = 2'd3;
    @(negedge clk);
    in_valid = 1'b0;
    check("t2_branch", {32'b0, out_data}, 64'h0001_FFFC);
    @(negedge clk);

    // 3: eight back-to-back
    for (int i = 0; i < 8; i++) begin
      check("t3_in_ready", {63'b0, in_ready}, 64'd1);
      in_valid = 1'b1;
      in_imm   = 16'(i * 16'h1111 + 3);
      in_mode  = 2'(i);
      @(negedge clk);
      check("t3_out_valid", {63'b0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);

    // 4: downstream stalled, three offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'hA001; in_mode = 2'd1;
    @(negedge clk);
    in_imm = 16'hA002;
    @(negedge clk);
    in_imm = 16'hA003;
    check("t4_ready_drop", {63'b0, in_ready}, 64'd0);
    @(negedge clk);
    check("t4_ready_held", {63'b0, in_ready}, 64'd0);
    check("t4_first_out", {32'b0, out_data}, 64'h0000_A001);
    out_ready = 1'b1;
    waited = 0;
    while (!in_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("t4_ready_returns", {63'b0, waited < 10}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);

    // 5: reset with both entries full
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h1234; in_mode = 2'd0;
    @(negedge clk);
    in_imm = 16'h5678;
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_out_valid", {63'b0, out_valid}, 64'd0);
    check("t5_in_ready", {63'b0, in_ready}, 64'd0);
    check("t5_out_data", {32'b0, out_data}, 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("t5_in_ready_back", {63'b0, in_ready}, 64'd1);
    check("t5_no_stale", {63'b0, out_valid}, 64'd0);

`ifdef IMM_EXT_STATS_EN
    // 6: five drains, three stall cycles
    out_ready = 1'b0;
    do_reset();
    check("t6_xfer_rst", {32'b0, xfer_count}, 64'd0);
    check("t6_stall_rst", {32'b0, stall_count}, 64'd0);
    in_valid = 1'b1; in_imm = 16'h0001; in_mode = 2'd1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      in_valid = 1'b1;
      in_imm   = 16'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("t6_xfer", {32'b0, xfer_count}, 64'd5);
    check("t6_stall", {32'b0, stall_count}, 64'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_xfer_clr", {32'b0, xfer_count}, 64'd0);
    check("t6_stall_clr", {32'b0, stall_count}, 64'd0);
`endif

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset     = ($urandom_range(0, 149) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_imm    = 16'($urandom);
      in_mode   = 2'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
